lelo_temp_core: RTL and testbench

LELO_TEMP_CORE -- requirements
Module: lelo_temp

---
 rtl/lelo_temp_core.sv | 97 +++++++++
 tb/tb_lelo_temp_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lelo_temp_core.sv
// Temperature-oscillator edge counter: counts synchronized osc rises over a 256<<win_sel window.
// Result/valid/done update on the clock edge closing the window; no backpressure, start is a level.
module lelo_temp_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  osc_sync;
  logic        osc_rise;
  logic        start;
  logic [15:0] edge_cnt_q, edge_cnt_d, edge_cnt_inc;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [15:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic        unused_bits;

  assign start    = ena & ui_in[0];
  assign osc_rise = osc_sync[1] & ~osc_sync[2];

  // Saturating increment: fast oscillators must pin at full scale, never wrap.
  always_comb begin
    edge_cnt_inc = edge_cnt_q;
    if (osc_rise && (edge_cnt_q != 16'hFFFF)) begin
      edge_cnt_inc = edge_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    win_cnt_d  = win_cnt_q;
    result_d   = result_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE, DONE: begin
        edge_cnt_d = 16'd0;
        if (start) begin
          state_d   = MEASURE;
          win_cnt_d = 16'd256 << ui_in[4:2];
        end else begin
          state_d = IDLE;
        end
      end
      MEASURE: begin
        if (!ena) begin
          state_d    = IDLE;
          edge_cnt_d = 16'd0;
          win_cnt_d  = 16'd0;
        end else begin
          edge_cnt_d = edge_cnt_inc;
          win_cnt_d  = win_cnt_q - 16'd1;
          // Last counted cycle: its own edge is folded into the latched result.
          if (win_cnt_q == 16'd1) begin
            result_d = edge_cnt_inc;
            valid_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      osc_sync   <= 3'b000;
      edge_cnt_q <= 16'd0;
      win_cnt_q  <= 16'd0;
      result_q   <= 16'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      osc_sync   <= {osc_sync[1:0], ui_in[1]};
      edge_cnt_q <= edge_cnt_d;
      win_cnt_q  <= win_cnt_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
    end
  end

  assign uo_out  = ui_in[7] ? result_q[15:8] : result_q[7:0];
  assign uio_out = {5'b00000, (state_q == DONE), (state_q == MEASURE), valid_q};
  assign uio_oe  = 8'h07;

  assign unused_bits = &{1'b0, uio_in, ui_in[6:5]};

endmodule

// File: tb/tb_lelo_temp_core.sv
// Randomized bench for lelo_temp_core; expected counts come from a recorded osc waveform
// and the window the DUT reports busy, shifted by the synchronizer latency.
module tb_lelo_temp_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       osc = 1'b0;
  logic       byte_sel = 1'b0;
  logic [2:0] win_sel = 3'd0;
  logic [1:0] junk = 2'd0;
  logic [7:0] ui_in;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int osc_per = 0;
  bit osc_hist [0:131071];

  always #5 clk = ~clk;

  assign ui_in = {byte_sel, junk, win_sel, osc, start};

  lelo_temp_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // Oscillator source: periodic square wave, random phase on each period change.
  initial begin : osc_gen
    int ph;
    int last_per;
    ph = 0;
    last_per = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (osc_per != last_per) begin
        last_per = osc_per;
        ph = (osc_per > 1) ? $urandom_range(osc_per - 1) : 0;
      end
      if (osc_per > 1) begin
        ph  = (ph + 1) % osc_per;
        osc = (ph < osc_per / 2);
      end else begin
        osc = 1'b0;
      end
      if (cyc < 131072) osc_hist[cyc] = osc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // A rise first driven in cycle c is seen by the counter in cycle c+2.
  function automatic int model_count(input int first, input int last);
    int cnt;
    cnt = 0;
    for (int c = first - 2; c <= last - 2; c++) begin
      if (c >= 1 && c < 131072 && osc_hist[c] && !osc_hist[c-1]) cnt++;
    end
    return (cnt > 65535) ? 65535 : cnt;
  endfunction

  task automatic read_result(output int r);
    int lo;
    int hi;
    byte_sel = 1'b0;
    #1;
    lo = int'(uo_out);
    byte_sel = 1'b1;
    #1;
    hi = int'(uo_out);
    byte_sel = 1'b0;
    r = hi * 256 + lo;
  endtask

  task automatic finish_window(output int n, output int d);
    n = 0;
    while (uio_out[1] && n < 40000) begin
      n++;
      tick();
    end
    d = cyc;
  endtask

  task automatic run_single(input int ws, input int per, output int res);
    int n;
    int d;
    win_sel = 3'(ws);
    osc_per = per;
    start   = 1'b1;
    tick();
    check("busy_on", int'(uio_out[1]), 1);
    start   = 1'b0;
    win_sel = 3'($urandom);
    junk    = 2'($urandom);
    uio_in  = 8'($urandom);
    finish_window(n, d);
    check("win_len", n, 256 << ws);
    check("done", int'(uio_out[2]), 1);
    check("valid", int'(uio_out[0]), 1);
    read_result(res);
    check("result", res, model_count(d - n, d - 1));
    tick();
    check("done_1cyc", int'(uio_out[2]), 0);
    check("idle_after", int'(uio_out[1]), 0);
  endtask

  initial begin : main
    int res;
    int prev;
    int n;
    int d;
    int dprev;

    repeat (3) tick();
    check("rst_uo", int'(uo_out), 0);
    check("rst_uio", int'(uio_out), 0);
    check("rst_oe", int'(uio_oe), 8'h07);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (50) tick();
    check("idle_uio", int'(uio_out), 0);
    check("idle_uo", int'(uo_out), 0);
    check("idle_oe", int'(uio_oe), 8'h07);

    run_single(0, 8, res);
    check("p8_near32", int'(res >= 31 && res <= 33), 1);
    run_single(3, 4, res);
    check("p4_near512", int'(res >= 511 && res <= 513), 1);

    for (int i = 0; i < 6; i++) begin
      run_single($urandom_range(2), $urandom_range(12, 2), res);
    end

    // ena low blocks starts
    ena   = 1'b0;
    start = 1'b1;
    repeat (5) tick();
    check("ena_block", int'(uio_out[1]), 0);
    start = 1'b0;
    ena   = 1'b1;
    tick();

    // Back-to-back windows with start held high
    win_sel = 3'd0;
    osc_per = 5;
    start   = 1'b1;
    tick();
    check("b2b_busy", int'(uio_out[1]), 1);
    dprev = 0;
    prev  = 0;
    for (int k = 0; k < 3; k++) begin
      finish_window(n, d);
      check("b2b_len", n, 256);
      check("b2b_done", int'(uio_out[2]), 1);
      read_result(prev);
      check("b2b_result", prev, model_count(d - n, d - 1));
      if (k > 0) check("b2b_period", d - dprev, 257);
      dprev = d;
      tick();
      check("b2b_rearm", int'(uio_out[1]), 1);
    end

    // Abort the fourth window with ena
    start = 1'b0;
    repeat ($urandom_range(200, 5)) tick();
    ena = 1'b0;
    tick();
    check("abort_busy", int'(uio_out[1]), 0);
    check("abort_done", int'(uio_out[2]), 0);
    check("abort_valid", int'(uio_out[0]), 1);
    read_result(res);
    check("abort_result", res, prev);
    repeat (3) tick();
    check("abort_nodone", int'(uio_out[2]), 0);
    ena = 1'b1;
    tick();

    run_single(7, 2, res);
    check("max_near16k", int'(res >= 16383 && res <= 16385), 1);

    // Reset in the middle of a window
    win_sel = 3'd7;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (1000) tick();
    check("pre_rst_busy", int'(uio_out[1]), 1);
    rst_n = 1'b0;
    #1;
    check("mrst_uio", int'(uio_out), 0);
    check("mrst_oe", int'(uio_oe), 8'h07);
    byte_sel = 1'b0;
    #1;
    check("mrst_lo", int'(uo_out), 0);
    byte_sel = 1'b1;
    #1;
    check("mrst_hi", int'(uo_out), 0);
    byte_sel = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_uio", int'(uio_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
